// File: rtl/sched_pkg.sv
// Shared types and defaults for the round-robin MMU scheduler.
package sched_pkg;

  localparam int NPROC_DEF  = 11;
  localparam int PIDW_DEF   = 4;
  localparam int KERNEL_PID = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_REQ  = 3'd2,
    ST_PICK = 3'd3,
    ST_LOAD = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] lower;
    logic [31:0] upper;
  } entry_t;

endpackage

// File: rtl/rr_next_pid.sv
// Wrap-around successor of a scan index over the user slots 1..NPROC-1.
module rr_next_pid
  import sched_pkg::*;
#(
  parameter int NPROC = NPROC_DEF,
  parameter int PIDW  = PIDW_DEF
) (
  input  logic [PIDW-1:0] idx_i,
  output logic [PIDW-1:0] next_o
);

  localparam logic [PIDW-1:0] LAST_ID = PIDW'(NPROC - 1);
  localparam logic [PIDW-1:0] ONE_ID  = PIDW'(1);

  // Slot 0 is skipped: the successor of the last slot (or of 0) lands on 1.
  always_comb begin
    next_o = ONE_ID;
    if (idx_i >= LAST_ID) begin
      next_o = ONE_ID;
    end else begin
      next_o = idx_i + ONE_ID;
    end
  end

endmodule

// File: rtl/mmu_scheduler.sv
// Round-robin process scheduler: times quanta, handshakes context switches
// with the CPU and programs the MMU segment of the next runnable process.
module mmu_scheduler
  import sched_pkg::*;
#(
  parameter int NPROC   = NPROC_DEF,
  parameter int PIDW    = PIDW_DEF,
  parameter int QUANTUM = 1000,
  parameter int QW      = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sched_en,
  input  logic            yield,
  input  logic            sw_ack,
  input  logic            cfg_we,
  input  logic [PIDW-1:0] cfg_id,
  input  logic            cfg_valid,
  input  logic [31:0]     cfg_lower,
  input  logic [31:0]     cfg_upper,
  output logic            mmu_we,
  output logic [15:0]     mmu_sel,
  output logic [31:0]     mmu_lower,
  output logic [31:0]     mmu_upper,
  output logic [PIDW-1:0] cur_pid,
  output logic            sw_req,
  output logic            sw_done,
  output logic            busy
);

  localparam logic [PIDW-1:0] NPROC_ID  = PIDW'(NPROC);
  localparam logic [PIDW-1:0] LAST_PICK = PIDW'(NPROC - 2);
  localparam logic [PIDW-1:0] KPID      = PIDW'(KERNEL_PID);
  localparam logic [PIDW-1:0] ONE_ID    = PIDW'(1);
  localparam logic [QW-1:0]   Q_LAST    = QW'(QUANTUM - 1);
  localparam logic [QW-1:0]   Q_ONE     = QW'(1);

  state_t          state_q, state_d;
  logic [QW-1:0]   cnt_q, cnt_d;
  logic [PIDW-1:0] cur_pid_q, cur_pid_d;
  logic [PIDW-1:0] scan_q, scan_d;
  logic [PIDW-1:0] pick_n_q, pick_n_d;
  logic [PIDW-1:0] load_pid_q, load_pid_d;
  logic [PIDW-1:0] cur_succ_s, scan_succ_s;
  entry_t          tbl_q [NPROC];
  entry_t          scan_ent_s, load_ent_s;

  rr_next_pid #(.NPROC(NPROC), .PIDW(PIDW)) u_cur_succ (
    .idx_i  (cur_pid_q),
    .next_o (cur_succ_s)
  );

  rr_next_pid #(.NPROC(NPROC), .PIDW(PIDW)) u_scan_succ (
    .idx_i  (scan_q),
    .next_o (scan_succ_s)
  );

  assign scan_ent_s = tbl_q[scan_q];
  assign load_ent_s = tbl_q[load_pid_q];

  // Process table; out-of-range slot ids are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NPROC; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (cfg_we && (cfg_id < NPROC_ID)) begin
      tbl_q[cfg_id] <= entry_t'{valid: cfg_valid, lower: cfg_lower, upper: cfg_upper};
    end
  end

  // FSM and datapath state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cur_pid_q  <= '0;
      scan_q     <= '0;
      pick_n_q   <= '0;
      load_pid_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_pid_q  <= cur_pid_d;
      scan_q     <= scan_d;
      pick_n_q   <= pick_n_d;
      load_pid_q <= load_pid_d;
    end
  end

  // Next-state logic; pick_n counts candidates already rejected this scan.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_pid_d  = cur_pid_q;
    scan_d     = scan_q;
    pick_n_d   = pick_n_q;
    load_pid_d = load_pid_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (sched_en) begin
          state_d  = ST_PICK;
          scan_d   = cur_succ_s;
          pick_n_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if ((cnt_q == Q_LAST) || yield) begin
          cnt_d   = '0;
          state_d = ST_REQ;
        end else if (!sched_en) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + Q_ONE;
        end
      end
      ST_REQ: begin
        if (sw_ack) begin
          state_d  = ST_PICK;
          scan_d   = cur_succ_s;
          pick_n_d = '0;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_PICK: begin
        if (scan_ent_s.valid) begin
          load_pid_d = scan_q;
          state_d    = ST_LOAD;
        end else if (pick_n_q == LAST_PICK) begin
          load_pid_d = KPID;
          state_d    = ST_LOAD;
        end else begin
          scan_d   = scan_succ_s;
          pick_n_d = pick_n_q + ONE_ID;
        end
      end
      ST_LOAD: begin
        cur_pid_d = load_pid_q;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        cnt_d = '0;
        if (sched_en) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decode registered state only; the MMU bus is zero outside LOAD.
  always_comb begin
    mmu_we    = 1'b0;
    mmu_sel   = 16'h0000;
    mmu_lower = 32'h0000_0000;
    mmu_upper = 32'h0000_0000;
    if (state_q == ST_LOAD) begin
      mmu_we    = 1'b1;
      mmu_sel   = 16'(load_pid_q);
      mmu_lower = load_ent_s.lower;
      mmu_upper = load_ent_s.upper;
    end else begin
      mmu_we = 1'b0;
    end
    cur_pid = cur_pid_q;
    sw_req  = (state_q == ST_REQ);
    sw_done = (state_q == ST_DONE);
    busy    = (state_q == ST_REQ) || (state_q == ST_PICK) ||
              (state_q == ST_LOAD) || (state_q == ST_DONE);
  end

endmodule

// File: doc/mmu_scheduler.md
Name: mmu_scheduler

Overview:
Round-robin process scheduler that owns the MMU segment-programming port.
- Holds a table of per-process segment limits (lower/upper).
- Times each process quantum and handshakes a context switch with the CPU.
- Selects the next valid process and writes its base/bound into the MMU with a one-cycle write pulse.
- Sits between the kernel configuration path and the MMU write interface (we/sel/lower/upper).

Parameters:
NPROC, 11, number of process slots; slot 0 is the kernel.
PIDW, 4, pid width; must satisfy 2^PIDW >= NPROC.
QUANTUM, 1000, run cycles per time slice; must be >= 2.
QW, 16, quantum counter width; must satisfy 2^QW > QUANTUM.

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
sched_en  in  1  scheduler enable.
yield  in  1  single-cycle pulse; current process gives up the CPU.
sw_ack  in  1  CPU has saved context; level, sampled only in REQ.
cfg_we  in  1  table write strobe.
cfg_id  in  PIDW  table slot to write; values >= NPROC are ignored.
cfg_valid  in  1  runnable flag written with the slot.
cfg_lower  in  32  segment lower limit.
cfg_upper  in  32  segment upper limit.
mmu_we  out  1  MMU write strobe.
mmu_sel  out  16  MMU segment selector; pid zero-extended.
mmu_lower  out  32  base written to MMU.
mmu_upper  out  32  bound written to MMU.
cur_pid  out  PIDW  pid of the running process.
sw_req  out  1  switch request to CPU.
sw_done  out  1  one-cycle pulse; new process is loaded.
busy  out  1  high in REQ, PICK, LOAD and DONE.

Behaviour:
- Reset values:
  - state=IDLE, all table entries cleared (valid=0, limits=0).
  - cur_pid=0, quantum counter=0, scan index=0.
  - All outputs 0.
- Table writes:
  - Accepted in any state, including mid-switch.
  - Take effect the next cycle.
  - A same-cycle read by PICK or LOAD sees the old value.
- States: IDLE, RUN, REQ, PICK, LOAD, DONE.
- IDLE:
  - sched_en=1 -> PICK.
  - No REQ on initial dispatch; there is no context to save.
- RUN:
  - Counter increments every cycle.
  - If counter==QUANTUM-1 or yield=1: counter<=0, go to REQ.
  - Else if sched_en=0: go to IDLE, counter<=0.
  - Expiry/yield take priority over sched_en=0.
  - yield outside RUN is ignored.
- REQ:
  - sw_req=1, held until sw_ack is sampled high.
  - On that edge: sw_req<=0, go to PICK.
- PICK:
  - Scans one candidate per cycle, starting at cur_pid+1.
  - Order runs up to NPROC-1, then wraps to 1; slot 0 is never a candidate.
  - First candidate with valid=1 -> LOAD.
  - After NPROC-1 candidates with no hit -> LOAD with pid 0 (kernel fallback).
  - The current pid is the last candidate, so a lone valid process is reselected.
  - Worst case is NPROC-1 cycles in PICK.
- LOAD (exactly 1 cycle):
  - mmu_we=1, mmu_sel={0, pid}.
  - mmu_lower and mmu_upper taken from the table (kernel fallback uses slot 0 contents).
  - cur_pid<=pid at the end of the cycle.
- DONE (1 cycle): sw_done=1. Then RUN if sched_en=1, else IDLE.
- sched_en dropping during REQ/PICK/LOAD: the switch still completes, then IDLE.
- Outside LOAD, mmu_we=0 and mmu_sel/mmu_lower/mmu_upper are 0.
- rst asserted mid-switch: everything returns to reset values next cycle; no mmu_we pulse is emitted.
- Latency:
  - Expiry edge -> sw_req high on the next cycle.
  - sw_ack sampled high -> mmu_we after k cycles, where k = PICK cycles (1..NPROC-1).
  - sw_done follows mmu_we by 1 cycle.

Decomposition:
- Package sched_pkg holds:
  - state enum (IDLE, RUN, REQ, PICK, LOAD, DONE)
  - NPROC and PIDW defaults
  - KERNEL_PID=0
  - table entry struct {valid, lower[31:0], upper[31:0]}
- One sub-module, rr_next_pid: combinational wrap-around successor of the scan index (1..NPROC-1).
  - The FSM, counter and table stay in mmu_scheduler.

Test Plan:
- Initial dispatch: QUANTUM=8; slot 3 valid {0x1000, 0x1FFF}; sched_en=1 after reset.
  -> PICK scans 1, 2, 3; mmu_we one cycle with sel=3, lower=0x1000, upper=0x1FFF; sw_done next cycle; cur_pid=3.
- Quantum expiry: slots 3 and 5 valid, running 3.
  -> sw_req exactly 8 cycles after entering RUN; hold sw_ack=0 for 4 cycles then 1; sw_req stays high until ack; then sel=5 loaded.
- Wrap and reselect: only slot 5 valid, running 5; pulse yield.
  -> scan 6..10, 1..5 (10 PICK cycles); reload sel=5, cur_pid stays 5.
- Kernel fallback: cfg clears slot 5's valid during REQ.
  -> after NPROC-1 PICK cycles, mmu_we with sel=0 and slot-0 limits; cur_pid=0.
- Boundaries: cfg_id=12 write ignored; yield on the same cycle as expiry gives exactly one REQ; sched_en=0 in PICK finishes the switch then IDLE; rst during PICK gives no mmu_we and all outputs 0.
